// File: rtl/jtdsp16_pkg.sv
// Shared types and widths for the DSP16 loop cache.
package jtdsp16_pkg;

  localparam int unsigned CACHE_DEPTH_DEF = 15;
  localparam int unsigned NI_W            = 4;
  localparam int unsigned K_W             = 7;
  localparam int unsigned INS_W           = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StReplay
  } cache_st_e;

endpackage

// File: rtl/jtdsp16_cache_mem.sv
// Loop body storage: one synchronous write port, one asynchronous read port, no reset.
module jtdsp16_cache_mem
  import jtdsp16_pkg::*;
#(
  parameter int unsigned DEPTH = CACHE_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [NI_W-1:0]  i_waddr,
  input  logic [INS_W-1:0] i_wdata,
  input  logic [NI_W-1:0]  i_raddr,
  output logic [INS_W-1:0] o_rdata
);

  logic [INS_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/jtdsp16_cache_ctrl.sv
// Hardware loop cache for "do K {N}": captures N words from ROM, then replays them K-1 times.
// Optional macro JTDSP16_CACHE_REDO_EN enables "redo K" replay of the last captured body.
module jtdsp16_cache_ctrl
  import jtdsp16_pkg::*;
#(
  parameter int unsigned CACHE_DEPTH = CACHE_DEPTH_DEF
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             cen,
  input  logic             ins_adv,
  input  logic             do_start,
  input  logic             redo_start,
  input  logic [NI_W-1:0]  ni,
  input  logic [K_W-1:0]   k,
  input  logic [INS_W-1:0] rom_dout,
  output logic [INS_W-1:0] cache_dout,
  output logic             up_xcache,
  output logic             pc_halt,
  output logic             irq_mask,
  output logic             loop_done
);

  localparam logic [NI_W-1:0] DepthN = NI_W'(CACHE_DEPTH);

  cache_st_e        r_state, w_state_nxt;
  logic [NI_W-1:0]  r_n, w_n_nxt;
  logic [NI_W-1:0]  r_idx, w_idx_nxt;
  logic [K_W-1:0]   r_k, w_k_nxt;
  logic [K_W-1:0]   r_rem, w_rem_nxt;
  logic             r_done, w_done_nxt;
  logic             w_we;
  logic             w_last;
  logic [NI_W-1:0]  w_ni_clamp;
  logic [INS_W-1:0] w_rdata;

`ifdef JTDSP16_CACHE_REDO_EN
  logic r_loaded, w_loaded_nxt;
`else
  logic w_unused;
  assign w_unused = redo_start;
`endif

  assign w_ni_clamp = (ni > DepthN) ? DepthN : ni;
  assign w_last     = (r_idx == r_n - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_n      <= '0;
      r_idx    <= '0;
      r_k      <= '0;
      r_rem    <= '0;
      r_done   <= 1'b0;
`ifdef JTDSP16_CACHE_REDO_EN
      r_loaded <= 1'b0;
`endif
    end else if (cen) begin
      r_state  <= w_state_nxt;
      r_n      <= w_n_nxt;
      r_idx    <= w_idx_nxt;
      r_k      <= w_k_nxt;
      r_rem    <= w_rem_nxt;
      r_done   <= w_done_nxt;
`ifdef JTDSP16_CACHE_REDO_EN
      r_loaded <= w_loaded_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_n_nxt      = r_n;
    w_idx_nxt    = r_idx;
    w_k_nxt      = r_k;
    w_rem_nxt    = r_rem;
    w_done_nxt   = 1'b0;
    w_we         = 1'b0;
`ifdef JTDSP16_CACHE_REDO_EN
    w_loaded_nxt = r_loaded;
`endif
    unique case (r_state)
      StIdle: begin
        // The do word itself is accepted here and is never captured.
        if (do_start && ni != '0) begin
          w_state_nxt  = StLoad;
          w_n_nxt      = w_ni_clamp;
          w_k_nxt      = k;
          w_idx_nxt    = '0;
`ifdef JTDSP16_CACHE_REDO_EN
          w_loaded_nxt = 1'b0;
`endif
        end
`ifdef JTDSP16_CACHE_REDO_EN
        else if (redo_start && r_loaded) begin
          w_state_nxt = StReplay;
          w_idx_nxt   = '0;
          w_rem_nxt   = (k == '0) ? K_W'(1) : k;
        end
`endif
      end
      StLoad: begin
        if (ins_adv) begin
          w_we      = 1'b1;
          w_idx_nxt = r_idx + 1'b1;
          if (w_last) begin
            w_idx_nxt    = '0;
`ifdef JTDSP16_CACHE_REDO_EN
            w_loaded_nxt = 1'b1;
`endif
            if (r_k <= K_W'(1)) begin
              w_state_nxt = StIdle;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = StReplay;
              w_rem_nxt   = r_k - 1'b1;
            end
          end
        end
      end
      StReplay: begin
        if (ins_adv) begin
          w_idx_nxt = r_idx + 1'b1;
          if (w_last) begin
            w_idx_nxt = '0;
            if (r_rem <= K_W'(1)) begin
              w_state_nxt = StIdle;
              w_done_nxt  = 1'b1;
            end else begin
              w_rem_nxt = r_rem - 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  jtdsp16_cache_mem #(
    .DEPTH (CACHE_DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we & cen),
    .i_waddr (r_idx),
    .i_wdata (rom_dout),
    .i_raddr (r_idx),
    .o_rdata (w_rdata)
  );

  assign up_xcache  = (r_state == StReplay);
  assign pc_halt    = (r_state == StReplay);
  assign irq_mask   = (r_state != StIdle);
  assign cache_dout = up_xcache ? w_rdata : '0;
  assign loop_done  = r_done;

endmodule
